pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the load/flush controls of the five-stage pipeline registers (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Resolves data-cache stalls, EX-stage redirects, load-use hazards and instruction-cache misses by priority.
//  Tracks an in-flight I-cache fetch squashed by a redirect and discards its late response.
//  Keeps stall-cycle and flush performance counters.
// PARAMETERS
//  CNT_W  32  width of stall_cycles / flush_count (saturating)
// PORTS
//  clk           in   1      clock; all state on posedge
//  rst           in   1      one clock; reset is asynchronous and active-low
//  icache_resp   in   1      fetch data valid this cycle for the current PC
//  dmem_req      in   1      MEM stage holds a load/store
//  dmem_resp     in   1      D-cache completes the MEM access this cycle
//  ex_redirect   in   1      EX resolved taken branch/jump; pcmux_out selects the target
//  ex_is_load    in   1      EX instruction is a load
//  ex_rd         in   5      EX destination register
//  id_rs1/id_rs2 in   5      ID source registers
//  id_use_rs1/2  in   1      ID actually reads rs1/rs2
//  load_pc       out  1      PC register load
//  load_if_id    out  1      IF_ID load
//  if_id_pop     out  1      pop_in to IF_ID; 1 marks the loaded word a bubble
//  load_id_ex    out  1      ID_EX load
//  bubble_id_ex  out  1      ID_EX loads a NOP instead of ID contents
//  load_ex_mem   out  1      EX_MEM load
//  load_mem_wb   out  1      MEM_WB load
//  ctrl_state    out  2      00 RUN, 01 DROP (discard in-flight fetch)
//  stall_cycles  out  CNT_W  cycles with load_ex_mem=0 or bubble_id_ex=1
//  flush_count   out  CNT_W  accepted redirects
// BEHAVIOUR
//  Reset (rst=0, async): state=RUN; counters=0.
//  While reset is asserted, all load_* outputs are 0, and if_id_pop=0 and bubble_id_ex=0.
//  Outputs are combinational from state and inputs (zero latency). Priority is highest first.
//  1 DSTALL, when dmem_req & ~dmem_resp: every load_* output=0; the state holds.
//  2 REDIRECT, when ex_redirect:
//    load_pc=1 and all back-end loads=1.
//    load_if_id=1 with if_id_pop=1, and bubble_id_ex=1.
//    flush_count is incremented.
//    If ~icache_resp, next state=DROP; otherwise next state=RUN.
//  3 LOAD-USE, when ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)):
//    load_pc=0, load_if_id=0, bubble_id_ex=1, back-end loads=1.
//  4 IMISS, when ~icache_resp:
//    load_pc=0, load_if_id=0, bubble_id_ex=1, back-end loads=1.
//  5 RUN: every load_* output=1, if_id_pop=0, bubble_id_ex=0.
//  DROP state: the fetch in flight belongs to the squashed PC.
//    While ~icache_resp: same outputs as IMISS.
//    When icache_resp: the word is dropped; load_pc=0 and load_if_id=1 with if_id_pop=1. Next state=RUN.
//    A DSTALL or REDIRECT in DROP takes priority per the list above; a REDIRECT stays in DROP, re-pointing PC.
//  DSTALL and LOAD-USE never change the state.
//  A DSTALL coinciding with ex_redirect defers the redirect: EX is frozen, so ex_redirect persists.
//  Counters saturate at all-ones and do not wrap.
//  Counters do not increment while rst=0.
//  Reset mid-DROP returns to RUN; the pending discard is lost, because the caches are also reset.
// TESTING
//  T1: rst low 3 cycles, then release with icache_resp=1 and no hazards.
//      -> all loads=1, state=RUN, counters=0.
//  T2: dmem_req=1 with dmem_resp low 4 cycles, then high.
//      -> all loads=0 for 4 cycles, then 1; stall_cycles=4.
//  T3: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1.
//      -> load_pc=0, load_if_id=0, bubble_id_ex=1, load_ex_mem=1 for that cycle.
//  T4: ex_redirect=1 with icache_resp=0, then icache_resp=1 after 3 cycles.
//      -> redirect cycle: load_pc=1, if_id_pop=1, state goes to DROP.
//      -> response cycle: load_if_id=1, if_id_pop=1, load_pc=0, state goes to RUN; flush_count=1.
//  T5: ex_redirect and load-use both asserted while dmem_req=1 and dmem_resp=0.
//      -> all loads=0; the redirect is taken on the first cycle dmem_resp=1.
//  T6: force stall_cycles to all-ones and keep stalling.
//      -> the value holds at all-ones and does not wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                     |
// | Load/flush sequencing for the five pipeline registers, with discard of   |
// | a redirect-squashed I-cache fetch and saturating stall/flush counters.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             ex_redirect,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             if_id_pop,
    output logic             load_id_ex,
    output logic             bubble_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_DROP = 2'b01
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic             w_dstall;
    logic             w_load_use;
    logic             w_flush_take;
    logic             w_stall_evt;

    assign w_dstall   = dmem_req & ~dmem_resp;
    assign w_load_use = ex_is_load & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));

    // A D-cache stall freezes everything, including a pending redirect in EX.
    always_comb begin
        w_state_nxt  = r_state;
        w_flush_take = 1'b0;
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        if_id_pop    = 1'b0;
        load_id_ex   = 1'b0;
        bubble_id_ex = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        if (rst && !w_dstall) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (ex_redirect) begin
                load_pc      = 1'b1;
                load_if_id   = 1'b1;
                if_id_pop    = 1'b1;
                bubble_id_ex = 1'b1;
                w_flush_take = 1'b1;
                // The fetch already in flight in DROP is stale whatever happens now.
                if (r_state == ST_DROP || !icache_resp) begin
                    w_state_nxt = ST_DROP;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end else if (r_state == ST_DROP) begin
                if (icache_resp) begin
                    load_if_id  = 1'b1;
                    if_id_pop   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    bubble_id_ex = 1'b1;
                end
            end else if (w_load_use || !icache_resp) begin
                bubble_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

    assign w_stall_evt = rst & (~load_ex_mem | bubble_id_ex);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_RUN;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall_evt && (r_stall_cycles != C_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + C_CNT_ONE;
            end
            if (w_flush_take && (r_flush_count != C_CNT_MAX)) begin
                r_flush_count <= r_flush_count + C_CNT_ONE;
            end
        end
    end

    assign ctrl_state   = r_state;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// Testbench for pipeline_hazard_ctrl: table vectors, directed corner sequences
// and random stimulus compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int W   = 8;
    localparam int MAX = (1 << W) - 1;

    // Packed load vector order: {pc, if_id, pop, id_ex, bubble, ex_mem, mem_wb}
    localparam logic [6:0] L_RUN   = 7'b1101011;
    localparam logic [6:0] L_HOLD  = 7'b0001111;
    localparam logic [6:0] L_STALL = 7'b0000000;
    localparam logic [6:0] L_REDIR = 7'b1111111;

    typedef struct packed {
        logic       icr;
        logic       dreq;
        logic       dresp;
        logic       redir;
        logic       exld;
        logic [4:0] exrd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [6:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic icache_resp = 1'b1, dmem_req = 1'b0, dmem_resp = 1'b0, ex_redirect = 1'b0, ex_is_load = 1'b0;
    logic [4:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic load_pc, load_if_id, if_id_pop, load_id_ex, bubble_id_ex, load_ex_mem, load_mem_wb;
    logic [1:0] ctrl_state;
    logic [W-1:0] stall_cycles, flush_count;

    int n_vec = 0;
    int n_err = 0;
    bit m_drop = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .icache_resp(icache_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .ex_redirect(ex_redirect), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .load_pc(load_pc), .load_if_id(load_if_id),
        .if_id_pop(if_id_pop), .load_id_ex(load_id_ex), .bubble_id_ex(bubble_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb), .ctrl_state(ctrl_state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    function automatic stim_t mk(input logic icr, dreq, dresp, redir, exld,
                                 input logic [4:0] exrd, rs1, rs2, input logic u1, u2);
        stim_t s;
        s.icr = icr; s.dreq = dreq; s.dresp = dresp; s.redir = redir; s.exld = exld;
        s.exrd = exrd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
        return s;
    endfunction

    // Reference: the priority list read straight off the behaviour rules.
    function automatic logic [6:0] ref_loads(input stim_t s, input bit drop, input bit rstn,
                                             output bit nxt_drop, output bit flush);
        bit hazard;
        hazard = s.exld && (s.exrd != 0) &&
                 ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd));
        nxt_drop = drop;
        flush = 0;
        if (!rstn) return L_STALL;
        if (s.dreq && !s.dresp) return L_STALL;
        if (s.redir) begin
            flush = 1;
            nxt_drop = drop || !s.icr;
            return L_REDIR;
        end
        if (drop) begin
            if (!s.icr) return L_HOLD;
            nxt_drop = 0;
            return 7'b0111011;
        end
        if (hazard || !s.icr) return L_HOLD;
        return L_RUN;
    endfunction

    task automatic step(input stim_t s, input logic rstv, input string tag, output logic [6:0] act);
        logic [6:0] exp_o;
        bit nd, fl;
        rst = rstv;
        icache_resp = s.icr; dmem_req = s.dreq; dmem_resp = s.dresp; ex_redirect = s.redir;
        ex_is_load = s.exld; ex_rd = s.exrd; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_use_rs1 = s.u1; id_use_rs2 = s.u2;
        @(negedge clk);
        if (!rstv) begin
            m_drop = 0; m_stall = 0; m_flush = 0;
        end
        exp_o = ref_loads(s, m_drop, rstv, nd, fl);
        act = {load_pc, load_if_id, if_id_pop, load_id_ex, bubble_id_ex, load_ex_mem, load_mem_wb};
        n_vec++;
        if (act !== exp_o || ctrl_state !== {1'b0, m_drop} ||
            stall_cycles !== W'(m_stall) || flush_count !== W'(m_flush)) begin
            n_err++;
            $display("FAIL %s: got loads=%b state=%0d stall=%0d flush=%0d, want loads=%b state=%0d stall=%0d flush=%0d",
                     tag, act, ctrl_state, stall_cycles, flush_count, exp_o, m_drop, m_stall, m_flush);
        end
        if (rstv) begin
            m_drop = nd;
            if (!exp_o[1] || exp_o[2]) m_stall = (m_stall >= MAX) ? MAX : m_stall + 1;
            if (fl) m_flush = (m_flush >= MAX) ? MAX : m_flush + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int actual, input int want);
        n_vec++;
        if (actual != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, actual, want);
        end
    endtask

    task automatic do_reset();
        logic [6:0] a;
        step(mk(1,0,0,0,0,0,0,0,0,0), 1'b0, "reset", a);
    endtask

    initial begin
        vec_t tbl[12];
        logic [6:0] a;
        stim_t idle, rs;
        bit rv;
        idle = mk(1,0,0,0,0,0,0,0,0,0);

        tbl[0]  = '{mk(1,0,0,0,0, 0, 0, 0,0,0), L_RUN,   "run"};
        tbl[1]  = '{mk(1,0,0,0,1, 5, 0, 5,0,1), L_HOLD,  "lu_rs2"};
        tbl[2]  = '{mk(1,0,0,0,1, 7, 7, 0,1,0), L_HOLD,  "lu_rs1"};
        tbl[3]  = '{mk(1,0,0,0,1, 0, 0, 0,1,1), L_RUN,   "lu_x0"};
        tbl[4]  = '{mk(1,0,0,0,1, 9, 9, 9,0,0), L_RUN,   "lu_nouse"};
        tbl[5]  = '{mk(1,0,0,0,0, 9, 9, 9,1,1), L_RUN,   "lu_noload"};
        tbl[6]  = '{mk(0,0,0,0,0, 0, 0, 0,0,0), L_HOLD,  "imiss"};
        tbl[7]  = '{mk(1,1,0,0,0, 0, 0, 0,0,0), L_STALL, "dstall"};
        tbl[8]  = '{mk(1,1,1,0,0, 0, 0, 0,0,0), L_RUN,   "dmem_done"};
        tbl[9]  = '{mk(1,0,0,1,0, 0, 0, 0,0,0), L_REDIR, "redir_hit"};
        tbl[10] = '{mk(1,1,0,1,1, 3, 3, 0,1,0), L_STALL, "redir_dstall"};
        tbl[11] = '{mk(0,0,0,0,1, 4, 0, 4,0,1), L_HOLD,  "lu_imiss"};

        // T1: reset held three cycles, then release into plain running
        #1;
        for (int i = 0; i < 3; i++) step(idle, 1'b0, "t1_reset", a);
        step(idle, 1'b1, "t1_run", a);
        chk("t1_stall0", stall_cycles, 0);
        chk("t1_flush0", flush_count, 0);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, 1'b1, tbl[i].name, a);
            n_vec++;
            if (a !== tbl[i].exp) begin
                n_err++;
                $display("FAIL tbl_%s: got loads=%b, want %b", tbl[i].name, a, tbl[i].exp);
            end
        end

        // T2: four D-cache stall cycles
        do_reset();
        for (int i = 0; i < 4; i++) step(mk(1,1,0,0,0,0,0,0,0,0), 1'b1, "t2_stall", a);
        step(mk(1,1,1,0,0,0,0,0,0,0), 1'b1, "t2_done", a);
        chk("t2_stall4", stall_cycles, 4);

        // T4: redirect during a miss, late response discarded
        do_reset();
        step(mk(0,0,0,1,0,0,0,0,0,0), 1'b1, "t4_redir", a);
        chk("t4_drop", ctrl_state, 1);
        for (int i = 0; i < 3; i++) step(mk(0,0,0,0,0,0,0,0,0,0), 1'b1, "t4_wait", a);
        step(idle, 1'b1, "t4_discard", a);
        chk("t4_run", ctrl_state, 0);
        chk("t4_flush1", flush_count, 1);
        step(idle, 1'b1, "t4_after", a);

        // T5: redirect and load-use deferred behind a D-cache stall
        do_reset();
        for (int i = 0; i < 2; i++) step(mk(1,1,0,1,1,5,5,0,1,0), 1'b1, "t5_held", a);
        step(mk(1,1,1,1,1,5,5,0,1,0), 1'b1, "t5_taken", a);
        chk("t5_flush1", flush_count, 1);

        // Redirect while dropping stays in DROP; reset mid-DROP returns to RUN
        do_reset();
        step(mk(0,0,0,1,0,0,0,0,0,0), 1'b1, "rd_first", a);
        step(mk(1,0,0,1,0,0,0,0,0,0), 1'b1, "rd_again", a);
        step(idle, 1'b1, "rd_discard", a);
        step(mk(0,0,0,1,0,0,0,0,0,0), 1'b1, "rst_drop_enter", a);
        step(idle, 1'b0, "rst_drop_reset", a);
        step(idle, 1'b1, "rst_drop_run", a);

        // T6: both counters pinned at all-ones
        do_reset();
        for (int i = 0; i < MAX + 10; i++) step(mk(1,1,0,0,0,0,0,0,0,0), 1'b1, "t6_stall", a);
        chk("t6_stall_sat", stall_cycles, MAX);
        for (int i = 0; i < MAX + 10; i++) step(mk(1,0,0,1,0,0,0,0,0,0), 1'b1, "t6_flush", a);
        chk("t6_flush_sat", flush_count, MAX);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rs.icr   = ($urandom % 4) != 0;
            rs.dreq  = ($urandom % 3) == 0;
            rs.dresp = $urandom % 2;
            rs.redir = ($urandom % 6) == 0;
            rs.exld  = $urandom % 2;
            rs.exrd  = 5'($urandom % 4);
            rs.rs1   = 5'($urandom % 4);
            rs.rs2   = 5'($urandom % 4);
            rs.u1    = m_drop ? 1'b0 : 1'($urandom % 2);
            rs.u2    = m_drop ? 1'b0 : 1'($urandom % 2);
            rv       = ($urandom % 150) != 0;
            step(rs, rv, "random", a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
